// File: rtl/vx_csr_rmw_unit.sv
// CSR read-modify-write initiator: issue -> combinational CSR port -> commit, one instruction in flight.
// Optional CSR_RMW_STATS_EN adds request / suppressed-write / response-stall counters.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif

module vx_csr_rmw_unit #(
    parameter int CORE_ID = 0,
    parameter int NT      = `NUM_THREADS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [`UUID_BITS-1:0]     req_uuid,
    input  logic [`NW_BITS-1:0]       req_wid,
    input  logic [NT-1:0]             req_tmask,
    input  logic [`NR_BITS-1:0]       req_rd,
    input  logic                      req_wb,
    input  logic [1:0]                req_op,
    input  logic [`CSR_ADDR_BITS-1:0] req_addr,
    input  logic [31:0]               req_src,
    output logic                      read_enable,
    output logic [`UUID_BITS-1:0]     read_uuid,
    output logic [`NW_BITS-1:0]       read_wid,
    output logic [`CSR_ADDR_BITS-1:0] read_addr,
    input  logic [31:0]               read_data,
    output logic                      write_enable,
    output logic [`UUID_BITS-1:0]     write_uuid,
    output logic [`NW_BITS-1:0]       write_wid,
    output logic [`CSR_ADDR_BITS-1:0] write_addr,
    output logic [31:0]               write_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [`UUID_BITS-1:0]     rsp_uuid,
    output logic [`NW_BITS-1:0]       rsp_wid,
    output logic [NT-1:0]             rsp_tmask,
    output logic [`NR_BITS-1:0]       rsp_rd,
    output logic                      rsp_wb,
    output logic [NT*32-1:0]          rsp_data,
    output logic                      busy
`ifdef CSR_RMW_STATS_EN
    ,
    output logic [31:0]               stat_reqs,
    output logic [31:0]               stat_wr_skips,
    output logic [31:0]               stat_rsp_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

    localparam logic [1:0] OP_RW = 2'd0;
    localparam logic [1:0] OP_RS = 2'd1;
    localparam logic [1:0] OP_RC = 2'd2;

    state_e                      state_q, state_d;
    logic [`UUID_BITS-1:0]       uuid_q, uuid_d;
    logic [`NW_BITS-1:0]         wid_q, wid_d;
    logic [NT-1:0]               tmask_q, tmask_d;
    logic [`NR_BITS-1:0]         rd_q, rd_d;
    logic                        wb_q, wb_d;
    logic [1:0]                  op_q, op_d;
    logic [`CSR_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]                 src_q, src_d;
    logic [31:0]                 old_q, old_d;

    function automatic logic [31:0] csr_new_val(input logic [1:0] op, input logic [31:0] old_v,
                                                input logic [31:0] src);
        case (op)
            OP_RS:   return old_v | src;
            OP_RC:   return old_v & ~src;
            default: return src;
        endcase
    endfunction

    // Illegal op 3 never writes; RS/RC with a zero mask are pure reads.
    function automatic logic csr_write_allowed(input logic [1:0] op, input logic [31:0] src);
        case (op)
            OP_RW:        return 1'b1;
            OP_RS, OP_RC: return (src != 32'd0);
            default:      return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        uuid_d       = uuid_q;
        wid_d        = wid_q;
        tmask_d      = tmask_q;
        rd_d         = rd_q;
        wb_d         = wb_q;
        op_d         = op_q;
        addr_d       = addr_q;
        src_d        = src_q;
        old_d        = old_q;
        req_ready    = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    uuid_d  = req_uuid;
                    wid_d   = req_wid;
                    tmask_d = req_tmask;
                    rd_d    = req_rd;
                    wb_d    = req_wb;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    src_d   = req_src;
                    state_d = RD;
                end
            end
            RD: begin
                // Op 3 reads like RW: only when the result is actually written back.
                read_enable = ((op_q == OP_RS) || (op_q == OP_RC)) || wb_q;
                old_d       = read_enable ? read_data : 32'd0;
                state_d     = WR;
            end
            WR: begin
                write_enable = csr_write_allowed(op_q, src_q);
                state_d      = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        uuid_q  <= uuid_d;
        wid_q   <= wid_d;
        tmask_q <= tmask_d;
        rd_q    <= rd_d;
        wb_q    <= wb_d;
        op_q    <= op_d;
        addr_q  <= addr_d;
        src_q   <= src_d;
        old_q   <= old_d;
    end

    assign read_uuid  = uuid_q;
    assign read_wid   = wid_q;
    assign read_addr  = addr_q;
    assign write_uuid = uuid_q;
    assign write_wid  = wid_q;
    assign write_addr = addr_q;
    assign write_data = csr_new_val(op_q, old_q, src_q);
    assign rsp_uuid   = uuid_q;
    assign rsp_wid    = wid_q;
    assign rsp_tmask  = tmask_q;
    assign rsp_rd     = rd_q;
    assign rsp_wb     = wb_q;
    assign rsp_data   = {NT{old_q}};
    assign busy       = (state_q != IDLE);

    illegal_op_a: assert property (@(posedge clk) disable iff (!reset)
        (req_valid && req_ready) |-> (req_op != 2'd3))
        else $error("core%0d: illegal CSR op 3 accepted", CORE_ID);

`ifdef CSR_RMW_STATS_EN
    logic [31:0] reqs_q, reqs_d, skips_q, skips_d, stalls_q, stalls_d;

    always_comb begin
        reqs_d   = reqs_q;
        skips_d  = skips_q;
        stalls_d = stalls_q;
        if (req_valid && req_ready) reqs_d = reqs_q + 32'd1;
        if ((state_q == WR) && ((op_q == OP_RS) || (op_q == OP_RC)) && (src_q == 32'd0))
            skips_d = skips_q + 32'd1;
        if (rsp_valid && !rsp_ready) stalls_d = stalls_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            reqs_q   <= 32'd0;
            skips_q  <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            reqs_q   <= reqs_d;
            skips_q  <= skips_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_reqs       = reqs_q;
    assign stat_wr_skips   = skips_q;
    assign stat_rsp_stalls = stalls_q;
`endif

endmodule
